// File: rtl/bsg_mesh_router_age_input_fifo.sv
// Per-direction input FIFO for the age-arbitrated mesh router; every waiting flit's timestamp ages each cycle.
// Optional same-cycle bypass when empty is enabled by defining BSG_MESH_AGE_FIFO_BYPASS_EN.
module bsg_mesh_router_age_input_fifo #(
    parameter int width_p    = 8,
    parameter int ts_width_p = 4,
    parameter int els_p      = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [width_p-1:0]    data_i,
    input  logic [ts_width_p-1:0] ts_i,
    input  logic                  v_i,
    output logic                  ready_o,
    output logic [width_p-1:0]    data_o,
    output logic [ts_width_p-1:0] ts_o,
    output logic                  v_o,
    input  logic                  yumi_i
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic [cnt_w-1:0]      full_cnt = cnt_w'(els_p);
    localparam logic [ptr_w-1:0]      last_ptr = ptr_w'(els_p - 1);
    localparam logic [ts_width_p-1:0] ts_max   = '1;

    logic [ptr_w-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [ptr_w-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [cnt_w-1:0]      count_reg, count_next;
    logic [width_p-1:0]    data_mem [els_p];
    logic [ts_width_p-1:0] ts_mem   [els_p];
    logic                  empty, enq, deq, wr_en, rd_adv;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign ready_o = ~reset_i & (count_reg != full_cnt);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

`ifdef BSG_MESH_AGE_FIFO_BYPASS_EN
    // An arriving flit shows up on the head in the same cycle when nothing is stored;
    // if the router takes it right away it never touches storage.
    assign v_o    = ~reset_i & (~empty | enq);
    assign data_o = empty ? data_i : data_mem[rd_ptr_reg];
    assign ts_o   = empty ? ts_i : ts_mem[rd_ptr_reg];
    assign wr_en  = enq & ~(empty & deq);
    assign rd_adv = deq & ~empty;
`else
    assign v_o    = ~reset_i & ~empty;
    assign data_o = data_mem[rd_ptr_reg];
    assign ts_o   = ts_mem[rd_ptr_reg];
    assign wr_en  = enq;
    assign rd_adv = deq;
`endif

    always_comb begin
        rd_ptr_next = rd_adv ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        wr_ptr_next = wr_en ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        count_next  = count_reg;
        if (wr_en & ~rd_adv) begin
            count_next = count_reg + 1'b1;
        end else if (~wr_en & rd_adv) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Each slot owns its own timestamp register so all waiting flits can age in parallel.
    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_entry
            localparam logic [ptr_w-1:0] idx = ptr_w'(gi);
            logic                  valid_reg;
            logic [width_p-1:0]    data_reg;
            logic [ts_width_p-1:0] ts_reg;
            logic                  write_here, read_here;

            assign write_here = wr_en & (wr_ptr_reg == idx);
            assign read_here  = rd_adv & (rd_ptr_reg == idx);

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    valid_reg <= 1'b0;
                end else if (write_here) begin
                    valid_reg <= 1'b1;
                end else if (read_here) begin
                    valid_reg <= 1'b0;
                end

                if (write_here) begin
                    data_reg <= data_i;
                    ts_reg   <= ts_i;
                end else if (~reset_i & valid_reg & ~read_here & (ts_reg != ts_max)) begin
                    ts_reg <= ts_reg + 1'b1;
                end
            end

            assign data_mem[gi] = data_reg;
            assign ts_mem[gi]   = ts_reg;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o is low");
        end
    end

endmodule

// File: tb/tb_bsg_mesh_router_age_input_fifo.sv
// Bench for bsg_mesh_router_age_input_fifo: a depth-2 (4-bit ts) and a depth-3 (3-bit ts) instance
// share directed stimulus and are checked every cycle against a queue model plus literal expectations.
module tb_bsg_mesh_router_age_input_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v_i = 1'b1;
    logic [7:0] data_i = '0;
    logic [3:0] ts_i = '0;
    logic       yumi_req = 1'b0;

    logic       ready2, v2, yumi2;
    logic [7:0] d2;
    logic [3:0] ts2;
    logic       ready3, v3, yumi3;
    logic [7:0] d3;
    logic [2:0] ts3;

    int nvec = 0;
    int nerr = 0;
    int ncyc = 0;

    always #5 clk = ~clk;

    // The router only pulses yumi while the head is valid.
    assign yumi2 = yumi_req & v2;
    assign yumi3 = yumi_req & v3;

    bsg_mesh_router_age_input_fifo #(.width_p(8), .ts_width_p(4), .els_p(2)) u2 (
        .clk_i(clk), .reset_i(rst), .data_i(data_i), .ts_i(ts_i), .v_i(v_i),
        .ready_o(ready2), .data_o(d2), .ts_o(ts2), .v_o(v2), .yumi_i(yumi2)
    );

    bsg_mesh_router_age_input_fifo #(.width_p(8), .ts_width_p(3), .els_p(3)) u3 (
        .clk_i(clk), .reset_i(rst), .data_i(data_i), .ts_i(ts_i[2:0]), .v_i(v_i),
        .ready_o(ready3), .data_o(d3), .ts_o(ts3), .v_o(v3), .yumi_i(yumi3)
    );

    // Behavioural model: per instance, an ordered list of {data, age}.
    int         depth [2] = '{2, 3};
    int         tsmax [2] = '{15, 7};
    logic [7:0] md [2][4];
    int         mt [2][4];
    int         mn [2] = '{0, 0};

    logic       a_v [2], a_r [2], a_y [2];
    logic [7:0] a_d [2];
    logic [3:0] a_t [2];
    assign a_v[0] = v2;     assign a_v[1] = v3;
    assign a_r[0] = ready2; assign a_r[1] = ready3;
    assign a_y[0] = yumi2;  assign a_y[1] = yumi3;
    assign a_d[0] = d2;     assign a_d[1] = d3;
    assign a_t[0] = ts2;    assign a_t[1] = {1'b0, ts3};

    logic       e_v [2], e_r [2], p_enq [2], p_deq [2], p_byp [2];
    logic [7:0] e_d [2];
    int         e_t [2], p_t [2];
    logic [7:0] p_d;
    logic       p_rst;
    logic       bypass_en;

    initial begin
        bypass_en = 1'b0;
`ifdef BSG_MESH_AGE_FIFO_BYPASS_EN
        bypass_en = 1'b1;
`endif
    end

    always begin
        @(negedge clk);
        ncyc++;
        p_rst = rst;
        p_d   = data_i;
        for (int k = 0; k < 2; k++) begin
            p_t[k]   = int'(ts_i) & tsmax[k];
            e_r[k]   = !rst && (mn[k] < depth[k]);
            p_enq[k] = v_i && e_r[k];
            p_byp[k] = bypass_en && p_enq[k] && (mn[k] == 0);
            e_v[k]   = !rst && ((mn[k] > 0) || p_byp[k]);
            e_d[k]   = (mn[k] > 0) ? md[k][0] : data_i;
            e_t[k]   = (mn[k] > 0) ? mt[k][0] : p_t[k];
            p_deq[k] = a_y[k] && e_v[k];

            nvec++;
            if (a_r[k] !== e_r[k]) begin
                nerr++;
                $display("FAIL cyc%0d u%0d ready_o got %b want %b", ncyc, k, a_r[k], e_r[k]);
            end
            nvec++;
            if (a_v[k] !== e_v[k]) begin
                nerr++;
                $display("FAIL cyc%0d u%0d v_o got %b want %b", ncyc, k, a_v[k], e_v[k]);
            end
            if (e_v[k]) begin
                nvec++;
                if (a_d[k] !== e_d[k] || int'(a_t[k]) != e_t[k] || $isunknown(a_t[k])) begin
                    nerr++;
                    $display("FAIL cyc%0d u%0d head got d=%h ts=%0d want d=%h ts=%0d",
                             ncyc, k, a_d[k], a_t[k], e_d[k], e_t[k]);
                end
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (p_rst) begin
                mn[k] = 0;
            end else begin
                if (p_deq[k] && mn[k] > 0) begin
                    for (int i = 0; i < 3; i++) begin
                        md[k][i] = md[k][i+1];
                        mt[k][i] = mt[k][i+1];
                    end
                    mn[k]--;
                end
                for (int i = 0; i < mn[k]; i++) begin
                    if (mt[k][i] < tsmax[k]) mt[k][i]++;
                end
                if (p_enq[k] && !(p_byp[k] && p_deq[k])) begin
                    md[k][mn[k]] = p_d;
                    mt[k][mn[k]] = p_t[k];
                    mn[k]++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // One cycle: drive after the rising edge, return after the falling edge so outputs are settled.
    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic [3:0] t,
                       input logic y);
        @(posedge clk);
        #1;
        rst = r; v_i = v; data_i = d; ts_i = t; yumi_req = y;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset held with the link valid
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 8'hEE, 4'd1, 0);
            chk("reset_v_o", 32'(v2), 32'd0);
            chk("reset_ready_o", 32'(ready2), 32'd0);
        end
        cyc(0, 0, 8'h00, 4'd0, 0);
        chk("post_reset_ready", 32'(ready2), 32'd1);
        chk("post_reset_v_o", 32'(v2), 32'd0);

        // Fill depth-2 instance, third flit refused, then drain in order
        cyc(0, 1, 8'hA1, 4'd5, 0);
        cyc(0, 1, 8'hB2, 4'd9, 0);
        cyc(0, 1, 8'hC3, 4'd1, 0);
        chk("full_ready", 32'(ready2), 32'd0);
        chk("full_head", 32'(d2), 32'hA1);
        cyc(0, 0, 8'h00, 4'd0, 1);
        chk("deq1_data", 32'(d2), 32'hA1);
        chk("deq1_ts", 32'(ts2), 32'd7);
        cyc(0, 0, 8'h00, 4'd0, 1);
        chk("deq2_data", 32'(d2), 32'hB2);
        chk("deq2_ts", 32'(ts2), 32'd11);
        cyc(0, 0, 8'h00, 4'd0, 0);
        chk("drained_v_o", 32'(v2), 32'd0);
        cyc(0, 0, 8'h00, 4'd0, 1);
        cyc(0, 0, 8'h00, 4'd0, 1);

        // Aging of a stalled head
        cyc(0, 1, 8'h33, 4'd3, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00, 4'd0, 0);
            chk("age_ts", 32'(ts2), 32'(3 + i));
        end
        cyc(0, 0, 8'h00, 4'd0, 1);

        // Saturation on the 3-bit timestamp instance
        cyc(0, 1, 8'h66, 4'd6, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'h00, 4'd0, 0);
            chk("sat_ts", 32'(ts3), (i == 0) ? 32'd6 : 32'd7);
        end
        cyc(0, 0, 8'h00, 4'd0, 1);

        // Full with a same-cycle yumi: dequeue happens, enqueue does not
        cyc(0, 1, 8'h41, 4'd0, 0);
        cyc(0, 1, 8'h42, 4'd0, 0);
        cyc(0, 1, 8'h43, 4'd0, 1);
        chk("full_yumi_ready", 32'(ready2), 32'd0);
        chk("full_yumi_head", 32'(d2), 32'h41);
        cyc(0, 1, 8'h43, 4'd0, 0);
        chk("after_yumi_ready", 32'(ready2), 32'd1);
        chk("after_yumi_head", 32'(d2), 32'h42);
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 4'd0, 1);

        // Reset in the middle of operation discards everything
        cyc(0, 1, 8'h51, 4'd0, 0);
        cyc(0, 1, 8'h52, 4'd0, 0);
        cyc(1, 0, 8'h00, 4'd0, 0);
        chk("mid_reset_v_o", 32'(v2), 32'd0);
        cyc(0, 0, 8'h00, 4'd0, 0);
        chk("after_mid_reset_v2", 32'(v2), 32'd0);
        chk("after_mid_reset_v3", 32'(v3), 32'd0);

        // Streaming through the depth-3 instance wraps its pointers
        cyc(0, 1, 8'd0, 4'd0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 8'(i), 4'd0, 1);
            chk("wrap_order", 32'(d3), 32'(i - 1));
        end
        for (int i = 0; i < 2; i++) cyc(0, 0, 8'h00, 4'd0, 1);

        // Empty FIFO, flit arrives with yumi already high
        cyc(0, 1, 8'hAB, 4'd2, 1);
        if (bypass_en) begin
            chk("byp_v_o", 32'(v2), 32'd1);
            chk("byp_data", 32'(d2), 32'hAB);
            chk("byp_ts", 32'(ts2), 32'd2);
            cyc(0, 0, 8'h00, 4'd0, 0);
            chk("byp_consumed", 32'(v2), 32'd0);
        end else begin
            chk("nobyp_v_o", 32'(v2), 32'd0);
            cyc(0, 0, 8'h00, 4'd0, 0);
            chk("nobyp_late_v_o", 32'(v2), 32'd1);
            chk("nobyp_late_data", 32'(d2), 32'hAB);
            chk("nobyp_late_ts", 32'(ts2), 32'd2);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 4'd0, 1);
        cyc(0, 0, 8'h00, 4'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
